// File: rtl/message_sequencer_pkg.sv
// message_sequencer_pkg: shared message codes, FSM states and counter width for the message sequencer
package message_sequencer_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {MSG_NONE = 2'd0, MSG_CRASH = 2'd1, MSG_VICTORY = 2'd2} msg_code_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_GAP = 2'd2} state_t;
  function automatic msg_code_t pick(input logic crash, input logic victory);
    return crash ? MSG_CRASH : (victory ? MSG_VICTORY : MSG_NONE);
  endfunction
endpackage

// File: rtl/message_sequencer_tick_counter.sv
// tick_counter: counts tick strobes up to limit; hit flags the tick that completes the interval
// ports: clk, reset (async active-low), clr (sync zero), tick, limit (last count value), hit
module tick_counter import message_sequencer_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);
  logic [CNT_W-1:0] count;
  assign hit = tick && count == limit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= (clr || hit) ? '0 : count + CNT_W'(tick);
endmodule

// File: rtl/message_sequencer.sv
// message_sequencer: shows crash/victory messages for a tick-timed dwell, blank gap between them
// ports: clk, reset (async active-low), tick, crash_req, victory_req, clear (sync abort)
//        msg_valid, msg_code, freeze, done
module message_sequencer import message_sequencer_pkg::*; #(
  parameter int unsigned DWELL_TICKS = 4,
  parameter int unsigned GAP_TICKS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       crash_req,
  input  logic       victory_req,
  input  logic       clear,
  output logic       msg_valid,
  output logic [1:0] msg_code,
  output logic       freeze,
  output logic       done
);
  state_t state, state_n;
  msg_code_t code, code_n;
  logic crash_pend, victory_pend, cp_n, vp_n, done_n, clr, hit;
  logic [CNT_W-1:0] limit;
  logic eff_c, eff_v;
  assign eff_c = crash_req || crash_pend;
  assign eff_v = victory_req || victory_pend;
  assign limit = state == ST_SHOW ? CNT_W'(DWELL_TICKS - 1) : CNT_W'(GAP_TICKS - 1);
  tick_counter u_cnt (.clk(clk), .reset(reset), .clr(clr), .tick(tick), .limit(limit), .hit(hit));
  always_comb begin
    state_n = state;
    code_n  = code;
    cp_n    = crash_pend;
    vp_n    = victory_pend;
    done_n  = 1'b0;
    clr     = 1'b0;
    if (clear) begin
      state_n = ST_IDLE;
      cp_n    = 1'b0;
      vp_n    = 1'b0;
      clr     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          clr  = 1'b1;
          cp_n = 1'b0;
          vp_n = eff_c && eff_v;
          if (eff_c || eff_v) begin
            state_n = ST_SHOW;
            code_n  = pick(eff_c, eff_v);
          end
        end
        ST_SHOW: begin
          if (crash_req && code == MSG_VICTORY) begin
            // crash preempts the victory, which is dropped rather than re-queued
            code_n = MSG_CRASH;
            clr    = 1'b1;
            vp_n   = 1'b0;
          end else begin
            vp_n = victory_pend || (victory_req && code == MSG_CRASH);
            if (hit) begin
              state_n = ST_GAP;
              done_n  = 1'b1;
            end
          end
        end
        ST_GAP: begin
          cp_n = eff_c;
          vp_n = eff_v;
          if (hit) begin
            state_n = (eff_c || eff_v) ? ST_SHOW : ST_IDLE;
            code_n  = (eff_c || eff_v) ? pick(eff_c, eff_v) : code;
            cp_n    = 1'b0;
            vp_n    = eff_c && eff_v;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= ST_IDLE;
      code         <= MSG_NONE;
      crash_pend   <= 1'b0;
      victory_pend <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      code         <= code_n;
      crash_pend   <= cp_n;
      victory_pend <= vp_n;
      done         <= done_n;
    end
  assign msg_valid = state == ST_SHOW;
  assign msg_code  = msg_valid ? code : MSG_NONE;
  assign freeze    = state != ST_IDLE;
endmodule

// File: tb/tb_message_sequencer.sv
// tb_message_sequencer: directed checks of message_sequencer with default dwell/gap
module tb_message_sequencer;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, crash_req = 1'b0, victory_req = 1'b0, clear = 1'b0;
  logic msg_valid, freeze, done;
  logic [1:0] msg_code;
  int total = 0, bad = 0;
  message_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .crash_req(crash_req), .victory_req(victory_req),
    .clear(clear), .msg_valid(msg_valid), .msg_code(msg_code), .freeze(freeze), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [1:0] c, input logic f, input logic d);
    chk(tag, {27'd0, msg_valid, msg_code, freeze, done}, {27'd0, v, c, f, d});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask
  task automatic req(input logic c, input logic v);
    crash_req = c;
    victory_req = v;
    cyc();
    crash_req = 1'b0;
    victory_req = 1'b0;
  endtask
  initial begin
    #2 reset = 1'b0;
    cyc();
    expect_out("reset", 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (9) cyc();
    expect_out("idle", 0, 0, 0, 0);
    // crash alone: 4-tick dwell, 1-tick gap
    req(1, 0);
    expect_out("crash_show", 1, 1, 1, 0);
    repeat (3) tk();
    expect_out("crash_dwell3", 1, 1, 1, 0);
    tk();
    expect_out("crash_done", 0, 0, 1, 1);
    cyc();
    expect_out("crash_gap", 0, 0, 1, 0);
    tk();
    expect_out("crash_idle", 0, 0, 0, 0);
    // both together: crash first, victory straight after the gap
    req(1, 1);
    expect_out("both_crash", 1, 1, 1, 0);
    repeat (4) tk();
    expect_out("both_done", 0, 0, 1, 1);
    tk();
    expect_out("both_victory", 1, 2, 1, 0);
    repeat (4) tk();
    expect_out("both_vdone", 0, 0, 1, 1);
    tk();
    expect_out("both_idle", 0, 0, 0, 0);
    // preempt: victory, 2 ticks, crash with a simultaneous tick that must not count
    req(0, 1);
    expect_out("pre_victory", 1, 2, 1, 0);
    repeat (2) tk();
    tick = 1'b1;
    req(1, 0);
    tick = 1'b0;
    expect_out("pre_switch", 1, 1, 1, 0);
    repeat (3) tk();
    expect_out("pre_dwell3", 1, 1, 1, 0);
    tk();
    expect_out("pre_done", 0, 0, 1, 1);
    tk();
    expect_out("pre_idle", 0, 0, 0, 0);
    cyc();
    expect_out("pre_no_victory", 0, 0, 0, 0);
    // victory request during the gap of a crash
    req(1, 0);
    repeat (4) tk();
    req(0, 1);
    expect_out("gap_pend", 0, 0, 1, 0);
    tk();
    expect_out("gap_victory", 1, 2, 1, 0);
    repeat (4) tk();
    tk();
    expect_out("gap_idle", 0, 0, 0, 0);
    // clear with victory pending; crash in the same cycle is discarded
    req(1, 1);
    clear = 1'b1;
    req(1, 0);
    clear = 1'b0;
    expect_out("clr_idle", 0, 0, 0, 0);
    repeat (6) tk();
    expect_out("clr_stay", 0, 0, 0, 0);
    // asynchronous reset mid-show
    req(1, 0);
    tk();
    expect_out("rst_show", 1, 1, 1, 0);
    reset = 1'b0;
    #1;
    expect_out("rst_async", 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (6) tk();
    expect_out("rst_stay", 0, 0, 0, 0);
    req(0, 1);
    expect_out("rst_new", 1, 2, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
